i2c_init_sequencer: RTL and testbench

Controller that owns the single-byte I2C register-write engine (slave address / register / data, enable pulse, free status) and sequences it.
- After start, walks an external table of NUM_CMDS {register, data} entries to configure the audio codec.
- After init completes, arbitrates runtime single-register write requests (e.g. volume) onto the same engine.
- Sits between the top-level audio control logic and the I2C command block.

---
 rtl/i2c_init_sequencer_if.sv | 28 ++
 rtl/i2c_init_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_init_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_init_sequencer_if                                           |
// | Brief    : Engine command bus and runtime write request bundle.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface i2c_init_sequencer_if;
    logic [7:0] cmd_slave_addr;
    logic [7:0] cmd_register;
    logic [7:0] cmd_data;
    logic       cmd_enable;
    logic       cmd_free;
    logic       rt_req;
    logic [7:0] rt_reg;
    logic [7:0] rt_data;
    logic       rt_ack;

    modport master (
        output cmd_slave_addr, cmd_register, cmd_data, cmd_enable, rt_ack,
        input  cmd_free, rt_req, rt_reg, rt_data
    );

    modport slave (
        input  cmd_slave_addr, cmd_register, cmd_data, cmd_enable, rt_ack,
        output cmd_free, rt_req, rt_reg, rt_data
    );
endinterface
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_init_sequencer                                              |
// | Brief    : Walks a codec init table onto a single-byte I2C write engine,   |
// |            then arbitrates runtime register writes. I2C_SEQ_RETRY_EN adds  |
// |            up to three retries per command on engine timeout.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2c_init_sequencer #(
    parameter int         NUM_CMDS       = 16,
    parameter logic [7:0] SLAVE_ADDR     = 8'h34,
    parameter int         GAP_CYCLES     = 1000,
    parameter int         TIMEOUT_CYCLES = 1048576
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    output logic [7:0]           tbl_idx,
    input  logic [15:0]          tbl_entry,
    output logic                 busy,
    output logic                 init_done,
    output logic                 error,
    i2c_init_sequencer_if.master bus
);

    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_LAST_IDX = 8'(NUM_CMDS - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_ISSUE     = 4'd2,
        S_WAIT_BUSY = 4'd3,
        S_WAIT_FREE = 4'd4,
        S_GAP       = 4'd5,
        S_DONE_IDLE = 4'd6,
        S_ERROR     = 4'd7,
        S_RETRY_GAP = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_src_rt;
    logic                 r_init_done;
    logic [7:0]           r_slave;
    logic [7:0]           r_reg;
    logic [7:0]           r_data;

    logic w_cnt_clr;
    logic w_idx_clr;
    logic w_idx_inc;
    logic w_set_done;
    logic w_clr_done;
    logic w_load_tbl;
    logic w_load_rt;
    logic w_rt_ack;
    logic w_can_retry;
    logic w_gap_last;
    logic w_timeout;

    assign w_gap_last = (r_cnt == c_GAP_LAST);
    assign w_timeout  = (r_cnt == c_TO_LAST);

`ifdef I2C_SEQ_RETRY_EN
    logic [1:0] r_retry;

    assign w_can_retry = (r_retry != 2'd3);

    // Retry budget is per command: cleared on every successful completion and on start.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_retry <= 2'd0;
        end else if (w_clr_done || (r_state == S_WAIT_FREE && w_state_nxt == S_GAP)) begin
            r_retry <= 2'd0;
        end else if (w_state_nxt == S_RETRY_GAP && r_state != S_RETRY_GAP) begin
            r_retry <= r_retry + 2'd1;
        end
    end
`else
    assign w_can_retry = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b1;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_set_done  = 1'b0;
        w_clr_done  = 1'b0;
        w_load_tbl  = 1'b0;
        w_load_rt   = 1'b0;
        w_rt_ack    = 1'b0;

        case (r_state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_clr   = 1'b1;
                    w_clr_done  = 1'b1;
                end
            end
            S_FETCH: begin
                w_load_tbl  = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_FREE: begin
                if (r_state == S_WAIT_BUSY && !bus.cmd_free) begin
                    w_state_nxt = S_WAIT_FREE;
                end else if (r_state == S_WAIT_FREE && bus.cmd_free) begin
                    w_state_nxt = S_GAP;
                end else if (w_timeout) begin
                    w_state_nxt = w_can_retry ? S_RETRY_GAP : S_ERROR;
                end else begin
                    w_cnt_clr = 1'b0;
                end
            end
            S_GAP: begin
                if (!w_gap_last) begin
                    w_cnt_clr = 1'b0;
                end else if (r_src_rt) begin
                    // Ack in the last gap cycle so the requester drops rt_req before DONE_IDLE samples it.
                    w_rt_ack    = 1'b1;
                    w_state_nxt = S_DONE_IDLE;
                end else if (r_idx == c_LAST_IDX) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = S_DONE_IDLE;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_RETRY_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_cnt_clr = 1'b0;
                end
            end
            S_DONE_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_clr   = 1'b1;
                    w_clr_done  = 1'b1;
                end else if (bus.rt_req) begin
                    w_load_rt   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_idx       <= 8'd0;
            r_cnt       <= '0;
            r_src_rt    <= 1'b0;
            r_init_done <= 1'b0;
            r_slave     <= 8'd0;
            r_reg       <= 8'd0;
            r_data      <= 8'd0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + c_CNT_W'(1);

            if (w_idx_clr) begin
                r_idx <= 8'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 8'd1;
            end

            if (w_clr_done) begin
                r_init_done <= 1'b0;
            end else if (w_set_done) begin
                r_init_done <= 1'b1;
            end

            if (w_load_tbl) begin
                r_slave  <= SLAVE_ADDR;
                r_reg    <= tbl_entry[15:8];
                r_data   <= tbl_entry[7:0];
                r_src_rt <= 1'b0;
            end else if (w_load_rt) begin
                r_slave  <= SLAVE_ADDR;
                r_reg    <= bus.rt_reg;
                r_data   <= bus.rt_data;
                r_src_rt <= 1'b1;
            end
        end
    end

    assign tbl_idx            = r_idx;
    assign init_done          = r_init_done;
    assign error              = (r_state == S_ERROR);
    assign busy               = !(r_state == S_IDLE || r_state == S_DONE_IDLE || r_state == S_ERROR);
    assign bus.cmd_slave_addr = r_slave;
    assign bus.cmd_register   = r_reg;
    assign bus.cmd_data       = r_data;
    assign bus.cmd_enable     = (r_state == S_ISSUE);
    assign bus.rt_ack         = w_rt_ack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for i2c_init_sequencer: behavioural engine model, expected-command queue,
// table of runtime writes and hand-written corner sequences.
module tb_i2c_init_sequencer;

    localparam int         c_NUM = 4;
    localparam int         c_GAP = 8;
    localparam int         c_TO  = 200;
    localparam logic [7:0] c_SA  = 8'h34;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
    } cmd_t;

    typedef struct {
        logic [7:0] in_reg;
        logic [7:0] in_data;
        logic [7:0] exp_reg;
        logic [7:0] exp_data;
        logic       exp_done;
        logic       exp_busy;
    } vec_t;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start     = 1'b0;
    logic [7:0]  tbl_idx;
    logic [15:0] tbl_entry;
    logic        busy;
    logic        init_done;
    logic        error;
    logic        eng_free  = 1'b1;
    logic        rt_req    = 1'b0;
    logic [7:0]  rt_reg    = 8'd0;
    logic [7:0]  rt_data   = 8'd0;

    logic [15:0] tbl_mem [c_NUM];
    cmd_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;
    int          en_count = 0;
    int          cyc = 0;
    int          last_en = -1000;
    int          eng_cnt = -1;
    int          hang_used = 0;
    int          hang_limit = 0;
    logic [7:0]  hang_reg = 8'hFF;

    i2c_init_sequencer_if bus();

    assign bus.cmd_free = eng_free;
    assign bus.rt_req   = rt_req;
    assign bus.rt_reg   = rt_reg;
    assign bus.rt_data  = rt_data;
    assign tbl_entry    = tbl_mem[tbl_idx[1:0]];

    i2c_init_sequencer #(
        .NUM_CMDS      (c_NUM),
        .SLAVE_ADDR    (c_SA),
        .GAP_CYCLES    (c_GAP),
        .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .tbl_idx  (tbl_idx),
        .tbl_entry(tbl_entry),
        .busy     (busy),
        .init_done(init_done),
        .error    (error),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine: free drops 2 cycles after enable and rises 50 cycles later; a hung command is ignored.
    always @(posedge sys_clk) begin
        if (bus.cmd_enable) begin
            if (bus.cmd_register == hang_reg && hang_used < hang_limit) begin
                hang_used <= hang_used + 1;
            end else begin
                eng_cnt <= 0;
            end
        end else if (eng_cnt >= 0) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 1)  eng_free <= 1'b0;
            if (eng_cnt == 51) begin
                eng_free <= 1'b1;
                eng_cnt  <= -1;
            end
        end
    end

    always @(negedge sys_clk) begin
        cmd_t e;
        cyc++;
        if (bus.cmd_enable) begin
            en_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_enable", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("cmd_register", {24'd0, bus.cmd_register}, {24'd0, e.r});
                check("cmd_data", {24'd0, bus.cmd_data}, {24'd0, e.d});
                check("cmd_slave_addr", {24'd0, bus.cmd_slave_addr}, {24'd0, c_SA});
            end
            check("enable_spacing_ok", {31'd0, (cyc - last_en) >= c_GAP + 3}, 32'd1);
            last_en = cyc;
        end
        if (bus.rt_ack) begin
            check("rt_ack_after_init_done", {31'd0, init_done}, 32'd1);
        end
    end

    function automatic bit cond(input int which, input int arg);
        case (which)
            0:       return init_done;
            1:       return error;
            2:       return bus.rt_ack;
            default: return en_count >= arg;
        endcase
    endfunction

    task automatic wait_for(input int which, input int arg, input int lim, input string name);
        int n = 0;
        while (!cond(which, arg) && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        total++;
        if (!cond(which, arg)) begin
            bad++;
            $display("FAIL wait_%s: not seen after %0d cycles, expected within bound", name, lim);
        end
    endtask

    task automatic push_tbl(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back(cmd_t'(tbl_mem[i]));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic rt_write(input logic [7:0] r, input logic [7:0] d);
        rt_reg  = r;
        rt_data = d;
        rt_req  = 1'b1;
        wait_for(2, 0, 400, "rt_ack");
        rt_req = 1'b0;
        @(negedge sys_clk);
        check("rt_ack_single_pulse", {31'd0, bus.rt_ack}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tbl_idx"}, {24'd0, tbl_idx}, 32'd0);
        check({tag, "_cmd_slave_addr"}, {24'd0, bus.cmd_slave_addr}, 32'd0);
        check({tag, "_cmd_register"}, {24'd0, bus.cmd_register}, 32'd0);
        check({tag, "_cmd_data"}, {24'd0, bus.cmd_data}, 32'd0);
        check({tag, "_cmd_enable"}, {31'd0, bus.cmd_enable}, 32'd0);
        check({tag, "_rt_ack"}, {31'd0, bus.rt_ack}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        vec_t vecs [3];
        int   base;
        int   n;

        tbl_mem[0] = 16'h0F00;
        tbl_mem[1] = 16'h0717;
        tbl_mem[2] = 16'h0A06;
        tbl_mem[3] = 16'h0901;
        vecs[0] = '{8'h02, 8'h79, 8'h02, 8'h79, 1'b1, 1'b0};
        vecs[1] = '{8'h03, 8'h5A, 8'h03, 8'h5A, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};

        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("idle_no_enable_count", en_count, 32'd0);

        // Plain init run
        push_tbl(0, 3);
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_for(0, 0, 2000, "init_done");
        check("init_enables", en_count, 32'd4);
        check("init_busy_low", {31'd0, busy}, 32'd0);
        check("init_queue_empty", exp_q.size(), 32'd0);

        // Runtime request held during init stalls until init_done
        push_tbl(0, 3);
        exp_q.push_back('{8'h02, 8'h79});
        pulse_start();
        check("init_done_cleared", {31'd0, init_done}, 32'd0);
        repeat (4) @(negedge sys_clk);
        rt_reg  = 8'h02;
        rt_data = 8'h79;
        rt_req  = 1'b1;
        wait_for(0, 0, 2000, "init_done_rt");
        n = 0;
        while (!bus.cmd_enable && n < 5) begin
            @(negedge sys_clk);
            n++;
        end
        check("rt_latency_ok", {31'd0, (n >= 1 && n <= 2)}, 32'd1);
        wait_for(2, 0, 400, "rt_ack_stall");
        rt_req = 1'b0;
        @(negedge sys_clk);
        check("rt_ack_one_cycle", {31'd0, bus.rt_ack}, 32'd0);
        check("rt_queue_empty", exp_q.size(), 32'd0);

        // Table of runtime writes from DONE_IDLE
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{vecs[i].exp_reg, vecs[i].exp_data});
            rt_write(vecs[i].in_reg, vecs[i].in_data);
            repeat (2) @(negedge sys_clk);
            check("vec_cmd_register_held", {24'd0, bus.cmd_register}, {24'd0, vecs[i].exp_reg});
            check("vec_cmd_data_held", {24'd0, bus.cmd_data}, {24'd0, vecs[i].exp_data});
            check("vec_init_done", {31'd0, init_done}, {31'd0, vecs[i].exp_done});
            check("vec_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
        end
        check("vec_queue_empty", exp_q.size(), 32'd0);

`ifdef I2C_SEQ_RETRY_EN
        // Entry 1 times out twice then succeeds
        hang_reg   = 8'h07;
        hang_limit = hang_used + 2;
        push_tbl(0, 1);
        push_tbl(1, 1);
        push_tbl(1, 3);
        pulse_start();
        wait_for(0, 0, 5000, "init_done_retry");
        check("retry_error_low", {31'd0, error}, 32'd0);
        check("retry_queue_empty", exp_q.size(), 32'd0);
        // Four timeouts fault
        hang_limit = hang_used + 4;
        push_tbl(0, 1);
        push_tbl(1, 1);
        push_tbl(1, 1);
        push_tbl(1, 1);
        pulse_start();
        wait_for(1, 0, 5000, "error_retry");
        check("retry_fault_busy", {31'd0, busy}, 32'd0);
        check("retry_fault_idx", {24'd0, tbl_idx}, 32'd1);
        check("retry_fault_queue", exp_q.size(), 32'd0);
`else
        // Entry 2 never starts: fault after timeout
        hang_reg   = 8'h0A;
        hang_limit = hang_used + 1;
        push_tbl(0, 2);
        pulse_start();
        wait_for(1, 0, 3000, "error");
        check("fault_busy", {31'd0, busy}, 32'd0);
        check("fault_idx", {24'd0, tbl_idx}, 32'd2);
        check("fault_init_done", {31'd0, init_done}, 32'd0);
        check("fault_queue", exp_q.size(), 32'd0);
        repeat (c_TO + 20) @(negedge sys_clk);
        check("fault_sticky", {31'd0, error}, 32'd1);
`endif
        // Restart from a fault
        push_tbl(0, 3);
        pulse_start();
        check("restart_error_clear", {31'd0, error}, 32'd0);
        check("restart_idx", {24'd0, tbl_idx}, 32'd0);
        wait_for(0, 0, 2000, "init_done_restart");
        check("restart_queue", exp_q.size(), 32'd0);

        // Reset during WAIT_FREE of entry 3
        push_tbl(0, 3);
        base = en_count;
        pulse_start();
        wait_for(3, base + 4, 2000, "entry3_enable");
        repeat (10) @(negedge sys_clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_reset_outputs("midreset");
        repeat (100) @(negedge sys_clk);
        check("no_resume_enables", en_count, base + 4);
        check("no_resume_done", {31'd0, init_done}, 32'd0);
        check("no_resume_busy", {31'd0, busy}, 32'd0);

        // start and rt_req together in DONE_IDLE: start wins, request served after new init
        push_tbl(0, 3);
        pulse_start();
        wait_for(0, 0, 2000, "init_done_pre");
        push_tbl(0, 3);
        exp_q.push_back('{8'h11, 8'h22});
        rt_reg  = 8'h11;
        rt_data = 8'h22;
        rt_req  = 1'b1;
        pulse_start();
        check("both_restart_done_low", {31'd0, init_done}, 32'd0);
        check("both_restart_busy", {31'd0, busy}, 32'd1);
        check("both_restart_idx", {24'd0, tbl_idx}, 32'd0);
        wait_for(2, 0, 3000, "rt_ack_both");
        rt_req = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("both_queue_empty", exp_q.size(), 32'd0);
        check("final_done", {31'd0, init_done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
